// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC check-node / bit-node output stages.
package ldpc_pkg;

  localparam int LDPC_W      = 8;  // message width, two's complement
  localparam int LDPC_DEG    = 6;  // check-node degree
  localparam int LDPC_IDXW   = 3;  // edge index width
  localparam int LDPC_OFFSET = 1;  // offset-min-sum correction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } cn_state_e;

  // Clip an unsigned magnitude to the largest positive w-bit two's-complement
  // value, then apply the offset correction with a floor at zero.
  // Works on 32-bit containers so callers of any width <= 32 can share it.
  function automatic logic [31:0] sat_abs_offset(input logic [31:0] mag,
                                                 input int unsigned w,
                                                 input logic [31:0] offset);
    logic [31:0] lim;
    logic [31:0] clip;
    lim  = (32'd1 << (w - 1)) - 32'd1;
    clip = (mag > lim) ? lim : mag;
    return (clip > offset) ? (clip - offset) : 32'd0;
  endfunction

endpackage

// File: rtl/ldpc_mag_corr.sv
// Combinational magnitude clip + offset correction + sign application.
// A zero corrected magnitude always yields 0 regardless of the sign.
module ldpc_mag_corr
  import ldpc_pkg::*;
#(
  parameter int W      = LDPC_W,
  parameter int OFFSET = LDPC_OFFSET
) (
  input  logic [W-1:0] mag,
  input  logic         neg,
  output logic [W-1:0] msg
);

  logic [W-1:0] m_corr;

  assign m_corr = W'(sat_abs_offset(32'(mag), W, 32'(OFFSET)));
  // Two's-complement negate; -0 folds to 0 naturally.
  assign msg    = neg ? (~m_corr + 1'b1) : m_corr;

endmodule

// File: rtl/ldpc_cn_msg_gen.sv
// Check-node output stage: captures a min/second-min/index/sign summary and
// emits DEG offset-min-sum check-to-bit messages serially, plus a parity flag.
module ldpc_cn_msg_gen
  import ldpc_pkg::*;
#(
  parameter int W      = LDPC_W,
  parameter int DEG    = LDPC_DEG,
  parameter int IDXW   = LDPC_IDXW,
  parameter int OFFSET = LDPC_OFFSET
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    min_mag,
  input  logic [IDXW-1:0] min_idx,
  input  logic [W-1:0]    smin_mag,
  input  logic [DEG-1:0]  sign_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_msg,
  output logic [IDXW-1:0] out_edge,
  output logic            out_last,
  output logic            chk_valid,
  output logic            chk_ok
);

  localparam logic [0:0]      IDLE      = ST_IDLE;
  localparam logic [0:0]      EMIT      = ST_EMIT;
  localparam logic [IDXW-1:0] LAST_EDGE = IDXW'(DEG - 1);

  logic [0:0]      state_reg;
  logic [W-1:0]    min_reg;
  logic [W-1:0]    smin_reg;
  logic [IDXW-1:0] idx_reg;
  logic [DEG-1:0]  sign_reg;
  logic            par_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [W-1:0]    out_msg_reg;
  logic [IDXW-1:0] out_edge_reg;
  logic            out_last_reg;
  logic            chk_valid_reg;
  logic            chk_ok_reg;

  // Operands of the beat that will be registered next. In IDLE the beat is
  // edge 0 of the summary being accepted, so the live inputs are used; in
  // EMIT it is the following edge of the captured summary.
  logic            is_idle;
  logic [IDXW-1:0] nxt_edge;
  logic [W-1:0]    sel_min;
  logic [W-1:0]    sel_smin;
  logic [IDXW-1:0] sel_idx;
  logic [DEG-1:0]  sel_sign;
  logic            sel_par;
  logic [W-1:0]    sel_mag;
  logic            sel_neg;
  logic [W-1:0]    nxt_msg;
  logic            xfer;

  assign is_idle  = (state_reg == IDLE);
  assign nxt_edge = is_idle ? '0 : (out_edge_reg + 1'b1);
  assign sel_min  = is_idle ? min_mag  : min_reg;
  assign sel_smin = is_idle ? smin_mag : smin_reg;
  assign sel_idx  = is_idle ? min_idx  : idx_reg;
  assign sel_sign = is_idle ? sign_in  : sign_reg;
  assign sel_par  = is_idle ? (^sign_in) : par_reg;
  // An out-of-range min_idx never matches, so every edge takes min_mag.
  assign sel_mag  = (nxt_edge == sel_idx) ? sel_smin : sel_min;
  assign sel_neg  = sel_par ^ ((int'(nxt_edge) < DEG) ? sel_sign[nxt_edge] : 1'b0);
  assign xfer     = out_valid_reg & out_ready;

  ldpc_mag_corr #(
    .W      (W),
    .OFFSET (OFFSET)
  ) u_mag_corr (
    .mag (sel_mag),
    .neg (sel_neg),
    .msg (nxt_msg)
  );

  // FSM, summary capture, edge counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      min_reg       <= '0;
      smin_reg      <= '0;
      idx_reg       <= '0;
      sign_reg      <= '0;
      par_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_msg_reg   <= '0;
      out_edge_reg  <= '0;
      out_last_reg  <= 1'b0;
      chk_valid_reg <= 1'b0;
      chk_ok_reg    <= 1'b0;
    end else begin
      chk_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            min_reg       <= min_mag;
            smin_reg      <= smin_mag;
            idx_reg       <= min_idx;
            sign_reg      <= sign_in;
            par_reg       <= ^sign_in;
            chk_valid_reg <= 1'b1;
            chk_ok_reg    <= ~(^sign_in);
            state_reg     <= EMIT;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            out_msg_reg   <= nxt_msg;
            out_edge_reg  <= '0;
            out_last_reg  <= (DEG == 1);
          end
        end
        default: begin
          if (xfer) begin
            if (out_edge_reg == LAST_EDGE) begin
              state_reg     <= IDLE;
              in_ready_reg  <= 1'b1;
              out_valid_reg <= 1'b0;
              out_msg_reg   <= '0;
              out_edge_reg  <= '0;
              out_last_reg  <= 1'b0;
            end else begin
              out_msg_reg   <= nxt_msg;
              out_edge_reg  <= nxt_edge;
              out_last_reg  <= (nxt_edge == LAST_EDGE);
            end
          end
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_msg   = out_msg_reg;
  assign out_edge  = out_edge_reg;
  assign out_last  = out_last_reg;
  assign chk_valid = chk_valid_reg;
  assign chk_ok    = chk_ok_reg;

endmodule

// File: tb/tb_ldpc_cn_msg_gen.sv
`timescale 1ns/1ps
module tb_ldpc_cn_msg_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] min_mag;
    logic [2:0] min_idx;
    logic [7:0] smin_mag;
    logic [5:0] sign_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_msg;
    logic [2:0] out_edge;
    logic       out_last;
    logic       chk_valid;
    logic       chk_ok;

    int errors = 0;
    int checks = 0;

    ldpc_cn_msg_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .min_mag   (min_mag),
        .min_idx   (min_idx),
        .smin_mag  (smin_mag),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_msg   (out_msg),
        .out_edge  (out_edge),
        .out_last  (out_last),
        .chk_valid (chk_valid),
        .chk_ok    (chk_ok)
    );

    always #5 clk = ~clk;

    task automatic fail(input string name, input logic [7:0] obs, input logic [7:0] expv);
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input string tag, input logic [7:0] mn, input logic [2:0] ix,
                             input logic [7:0] sm, input logic [5:0] sg,
                             input logic [47:0] expm, input logic ok, input int stall_e);
        min_mag  = mn;
        min_idx  = ix;
        smin_mag = sm;
        sign_in  = sg;
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1) fail({tag, " in_ready_idle"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (chk_valid !== 1'b1) fail({tag, " chk_valid"}, chk_valid, 1'b1);
        checks++; if (chk_ok !== ok) fail({tag, " chk_ok"}, chk_ok, ok);
        for (int e = 0; e < 6; e++) begin
            if (e == 1) begin
                checks++; if (chk_valid !== 1'b0) fail({tag, " chk_pulse_end"}, chk_valid, 1'b0);
            end
            checks++; if (out_valid !== 1'b1) fail($sformatf("%s out_valid e%0d", tag, e), out_valid, 1'b1);
            checks++; if (out_edge !== 3'(e)) fail($sformatf("%s out_edge e%0d", tag, e), out_edge, 3'(e));
            checks++; if (out_msg !== expm[8*e +: 8]) fail($sformatf("%s out_msg e%0d", tag, e), out_msg, expm[8*e +: 8]);
            checks++; if (out_last !== (e == 5)) fail($sformatf("%s out_last e%0d", tag, e), out_last, (e == 5));
            $display("%s: edge %0d msg %0h last %0b", tag, out_edge, out_msg, out_last);
            if (e == stall_e) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checks++; if (out_valid !== 1'b1) fail($sformatf("%s hold valid s%0d", tag, s), out_valid, 1'b1);
                    checks++; if (out_edge !== 3'(e)) fail($sformatf("%s hold edge s%0d", tag, s), out_edge, 3'(e));
                    checks++; if (out_msg !== expm[8*e +: 8]) fail($sformatf("%s hold msg s%0d", tag, s), out_msg, expm[8*e +: 8]);
                    checks++; if (in_ready !== 1'b0) fail($sformatf("%s hold in_ready s%0d", tag, s), in_ready, 1'b0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) fail({tag, " done out_valid"}, out_valid, 1'b0);
        checks++; if (in_ready !== 1'b1) fail({tag, " done in_ready"}, in_ready, 1'b1);
    endtask

    localparam logic [47:0] EXP_BASIC = {8'h02, 8'h02, 8'h02, 8'h04, 8'h02, 8'h02};
    localparam logic [47:0] EXP_SIGNS = {8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'h05};
    localparam logic [47:0] EXP_SAT0  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h00};
    localparam logic [47:0] EXP_NEG   = {8'h82, 8'h82, 8'h82, 8'h82, 8'h7E, 8'h82};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        min_mag   = '0;
        min_idx   = '0;
        smin_mag  = '0;
        sign_in   = '0;
        out_ready = 1'b1;
        #2;
        checks++; if (in_ready !== 1'b1) fail("reset in_ready", in_ready, 1'b1);
        checks++; if (out_valid !== 1'b0) fail("reset out_valid", out_valid, 1'b0);
        checks++; if (out_msg !== 8'h00) fail("reset out_msg", out_msg, 8'h00);
        checks++; if (chk_valid !== 1'b0) fail("reset chk_valid", chk_valid, 1'b0);
        checks++; if (chk_ok !== 1'b0) fail("reset chk_ok", chk_ok, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        run_check("basic",  8'd3,   3'd2, 8'd5,   6'b000000, EXP_BASIC, 1'b1, -1);
        run_check("signs",  8'd4,   3'd0, 8'd6,   6'b000001, EXP_SIGNS, 1'b0, -1);
        run_check("sat0",   8'd0,   3'd1, 8'd128, 6'b000000, EXP_SAT0,  1'b1, -1);
        run_check("sat1",   8'd1,   3'd1, 8'd128, 6'b000000, EXP_SAT0,  1'b1, -1);
        run_check("satneg", 8'd200, 3'd0, 8'd250, 6'b000010, EXP_NEG,   1'b0, -1);
        run_check("idx7",   8'd3,   3'd7, 8'd5,   6'b000000, {6{8'h02}}, 1'b1, -1);
        run_check("bp",     8'd3,   3'd2, 8'd5,   6'b000000, EXP_BASIC, 1'b1, 2);

        min_mag = 8'd3; min_idx = 3'd2; smin_mag = 8'd5; sign_in = 6'b000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        checks++; if (out_edge !== 3'd4) fail("pre-reset edge", out_edge, 3'd4);
        rst = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) fail("async rst out_valid", out_valid, 1'b0);
        checks++; if (out_msg !== 8'h00) fail("async rst out_msg", out_msg, 8'h00);
        checks++; if (out_edge !== 3'd0) fail("async rst out_edge", out_edge, 3'd0);
        checks++; if (out_last !== 1'b0) fail("async rst out_last", out_last, 1'b0);
        checks++; if (chk_ok !== 1'b0) fail("async rst chk_ok", chk_ok, 1'b0);
        checks++; if (in_ready !== 1'b1) fail("async rst in_ready", in_ready, 1'b1);
        $display("reset mid-emit: out_valid %0b in_ready %0b", out_valid, in_ready);
        rst = 1'b0;
        tick();
        run_check("post-rst", 8'd3, 3'd2, 8'd5, 6'b000000, EXP_BASIC, 1'b1, -1);

        min_mag = 8'd3; min_idx = 3'd2; smin_mag = 8'd5; sign_in = 6'b000000;
        in_valid = 1'b1;
        tick();
        min_mag = 8'd4; min_idx = 3'd0; smin_mag = 8'd6; sign_in = 6'b000001;
        for (int e = 0; e < 6; e++) begin
            checks++; if (in_ready !== 1'b0) fail($sformatf("b2b A in_ready e%0d", e), in_ready, 1'b0);
            checks++; if (out_edge !== 3'(e)) fail($sformatf("b2b A edge e%0d", e), out_edge, 3'(e));
            checks++; if (out_msg !== EXP_BASIC[8*e +: 8]) fail($sformatf("b2b A msg e%0d", e), out_msg, EXP_BASIC[8*e +: 8]);
            $display("b2b A: edge %0d msg %0h", out_edge, out_msg);
            tick();
        end
        checks++; if (out_valid !== 1'b0) fail("b2b bubble out_valid", out_valid, 1'b0);
        checks++; if (in_ready !== 1'b1) fail("b2b bubble in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (chk_valid !== 1'b1) fail("b2b B chk_valid", chk_valid, 1'b1);
        checks++; if (chk_ok !== 1'b0) fail("b2b B chk_ok", chk_ok, 1'b0);
        for (int e = 0; e < 6; e++) begin
            checks++; if (out_valid !== 1'b1) fail($sformatf("b2b B valid e%0d", e), out_valid, 1'b1);
            checks++; if (out_edge !== 3'(e)) fail($sformatf("b2b B edge e%0d", e), out_edge, 3'(e));
            checks++; if (out_msg !== EXP_SIGNS[8*e +: 8]) fail($sformatf("b2b B msg e%0d", e), out_msg, EXP_SIGNS[8*e +: 8]);
            $display("b2b B: edge %0d msg %0h", out_edge, out_msg);
            tick();
        end
        checks++; if (out_valid !== 1'b0) fail("b2b end out_valid", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
